// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-wide RAM port controller:
// FSM states, access-size codes, IO address window and the beat-count helper.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Stores into this 64 KiB window (addr[17:16]) land in the UART buffer.
  localparam logic [1:0] IO_RANGE = 2'b11;

  localparam int REQ_FCH = 0;
  localparam int REQ_LS  = 1;

  // Size code 2'b11 is not a legal access size and is widened to a word.
  function automatic logic [2:0] beat_count(input logic [1:0] size);
    case (size)
      SIZE_BYTE: beat_count = 3'd1;
      SIZE_HALF: beat_count = 3'd2;
      default:   beat_count = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_rr_arb.sv
// Two-way round-robin arbiter (bit 0 = fetch, bit 1 = load/store) with a
// registered priority pointer that flips only on contested grants.
module mem_rr_arb
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       take,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic prio_ls_reg;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = prio_ls_reg ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prio_ls_reg <= 1'b1;
    end else if (rdy && take && req == 2'b11) begin
      prio_ls_reg <= ~prio_ls_reg;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates fetch and load/store onto one byte-wide, one-read-latency RAM
// port, sequencing byte beats. Optional MEM_CTRL_IO_STALL_EN holds IO stores off.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              rollback_sign_from_rob,
  input  logic              fch_req,
  input  logic [ADDR_W-1:0] fch_addr,
  output logic              fch_done,
  output logic [31:0]       fch_data,
  input  logic              ls_req,
  input  logic              ls_wr,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] mem_a_reg;
  logic [2:0]        n_reg;
  logic [2:0]        step_reg;
  logic              is_ls_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       data_reg;
  logic [31:0]       fch_data_reg;
  logic [31:0]       ls_rdata_reg;
  logic [7:0]        mem_dout_reg;
  logic              mem_wr_reg;
  logic              fch_done_reg;
  logic              ls_done_reg;

  logic              ls_elig;
  logic [1:0]        grant;
  logic              take;
  logic [2:0]        next_step;
  logic [1:0]        cap_idx;
  logic [31:0]       read_word;

`ifdef MEM_CTRL_IO_STALL_EN
  assign ls_elig = ls_req && !(ls_wr && ls_addr[17:16] == IO_RANGE && io_buffer_full);
`else
  logic unused_io;
  assign unused_io = io_buffer_full;
  assign ls_elig   = ls_req;
`endif

  assign take = (state_reg == ST_IDLE) && !rollback_sign_from_rob && (grant != 2'b00);

  mem_rr_arb u_arb (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .take  (take),
    .req   ({ls_elig, fch_req}),
    .grant (grant)
  );

  assign next_step = step_reg + 3'd1;
  // The byte on mem_din belongs to the address issued one beat earlier.
  assign cap_idx   = step_reg[1:0] - 2'd1;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign read_word[8*gi +: 8] = (step_reg != 3'd0 && cap_idx == 2'(gi)) ?
                                    mem_din : data_reg[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      mem_a_reg    <= '0;
      n_reg        <= '0;
      step_reg     <= '0;
      is_ls_reg    <= 1'b0;
      wdata_reg    <= '0;
      data_reg     <= '0;
      fch_data_reg <= '0;
      ls_rdata_reg <= '0;
      mem_dout_reg <= '0;
      mem_wr_reg   <= 1'b0;
      fch_done_reg <= 1'b0;
      ls_done_reg  <= 1'b0;
    end else if (rdy) begin
      fch_done_reg <= 1'b0;
      ls_done_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (take) begin
            is_ls_reg <= grant[REQ_LS];
            data_reg  <= '0;
            step_reg  <= '0;
            if (grant[REQ_LS]) begin
              addr_reg  <= ls_addr;
              mem_a_reg <= ls_addr;
              n_reg     <= beat_count(ls_size);
              wdata_reg <= ls_wdata;
              if (ls_wr) begin
                state_reg    <= ST_WRITE;
                mem_wr_reg   <= 1'b1;
                mem_dout_reg <= ls_wdata[7:0];
              end else begin
                state_reg <= ST_READ;
              end
            end else begin
              addr_reg  <= fch_addr;
              mem_a_reg <= fch_addr;
              n_reg     <= 3'd4;
              state_reg <= ST_READ;
            end
          end
        end

        ST_READ: begin
          if (rollback_sign_from_rob) begin
            state_reg <= ST_IDLE;
            mem_a_reg <= '0;
            data_reg  <= '0;
            step_reg  <= '0;
          end else begin
            step_reg <= next_step;
            if (step_reg != 3'd0) begin
              data_reg <= read_word;
            end
            if (next_step < n_reg) begin
              mem_a_reg <= addr_reg + ADDR_W'(next_step);
            end else begin
              mem_a_reg <= '0;
            end
            if (step_reg == n_reg) begin
              state_reg <= ST_IDLE;
              if (is_ls_reg) begin
                ls_done_reg  <= 1'b1;
                ls_rdata_reg <= read_word;
              end else begin
                fch_done_reg <= 1'b1;
                fch_data_reg <= read_word;
              end
            end
          end
        end

        // Stores are already committed, so rollback does not stop them.
        ST_WRITE: begin
          step_reg <= next_step;
          if (next_step < n_reg) begin
            mem_a_reg    <= addr_reg + ADDR_W'(next_step);
            mem_dout_reg <= wdata_reg[{next_step[1:0], 3'b000} +: 8];
          end else begin
            state_reg    <= ST_IDLE;
            mem_a_reg    <= '0;
            mem_dout_reg <= '0;
            mem_wr_reg   <= 1'b0;
            ls_done_reg  <= 1'b1;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign mem_a    = mem_a_reg;
  assign mem_dout = mem_dout_reg;
  assign mem_wr   = mem_wr_reg & rdy;
  assign fch_done = fch_done_reg;
  assign fch_data = fch_data_reg;
  assign ls_done  = ls_done_reg;
  assign ls_rdata = ls_rdata_reg;

endmodule
